// File: rtl/imem_loader.sv
// Instruction memory loader: assembles a little-endian byte stream into 32-bit
// words, writes them from address 0 upward, and holds the CPU in reset meanwhile.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for a valid start; CPU held in reset
// RECV  | accepting stream bytes into the assembly register
// WRITE | single-cycle imem write of the assembled word
// DONE  | all words written; CPU released until the next start
module imem_loader #(
  parameter int NUM_WORDS  = 64,
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 7
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  word_count,
  input  logic [7:0]            byte_data,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int WIDX_W = ADDR_WIDTH - 2;

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  state_t                state, state_n;
  logic [1:0]            byte_idx, byte_idx_n;
  logic [WIDX_W-1:0]     word_idx, word_idx_n;
  logic [CNT_WIDTH-1:0]  count_q, count_n;
  logic [31:0]           asm_q, asm_n;
  logic                  byte_ready_n, imem_we_n, cpu_reset_n, busy_n, done_n, error_n;
  logic [ADDR_WIDTH-1:0] imem_addr_n;
  logic [31:0]           imem_wdata_n;
  logic                  start_ok;
  logic                  xfer;
  logic                  last_word;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      byte_idx   <= '0;
      word_idx   <= '0;
      count_q    <= '0;
      asm_q      <= '0;
      byte_ready <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_reset  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= state_n;
      byte_idx   <= byte_idx_n;
      word_idx   <= word_idx_n;
      count_q    <= count_n;
      asm_q      <= asm_n;
      byte_ready <= byte_ready_n;
      imem_we    <= imem_we_n;
      imem_addr  <= imem_addr_n;
      imem_wdata <= imem_wdata_n;
      cpu_reset  <= cpu_reset_n;
      busy       <= busy_n;
      done       <= done_n;
      error      <= error_n;
    end
  end

  always_comb begin
    state_n      = state;
    byte_idx_n   = byte_idx;
    word_idx_n   = word_idx;
    count_n      = count_q;
    asm_n        = asm_q;
    imem_addr_n  = imem_addr;
    imem_wdata_n = imem_wdata;
    error_n      = error;

    start_ok  = (word_count != '0) && (word_count <= CNT_WIDTH'(NUM_WORDS));
    xfer      = byte_valid && byte_ready;
    last_word = (CNT_WIDTH'(word_idx) == (count_q - CNT_WIDTH'(1)));

    case (state)
      IDLE, DONE: begin
        if (start) begin
          if (start_ok) begin
            count_n    = word_count;
            error_n    = 1'b0;
            byte_idx_n = '0;
            word_idx_n = '0;
            state_n    = RECV;
          end else begin
            error_n = 1'b1;
            state_n = IDLE;
          end
        end
      end
      RECV: begin
        if (xfer) begin
          asm_n[{byte_idx, 3'b000} +: 8] = byte_data;
          byte_idx_n = byte_idx + 2'd1;
          if (byte_idx == 2'd3) begin
            // Present the word including the byte arriving this cycle.
            imem_addr_n  = {word_idx, 2'b00};
            imem_wdata_n = {byte_data, asm_q[23:0]};
            state_n      = WRITE;
          end
        end
      end
      WRITE: begin
        if (last_word) begin
          state_n = DONE;
        end else begin
          word_idx_n = word_idx + WIDX_W'(1);
          state_n    = RECV;
        end
      end
      default: state_n = IDLE;
    endcase

    // Outputs are registered: derive them from the state being entered.
    byte_ready_n = (state_n == RECV);
    imem_we_n    = (state_n == WRITE);
    cpu_reset_n  = (state_n == DONE);
    done_n       = (state_n == DONE);
    busy_n       = (state_n == RECV) || (state_n == WRITE);
  end

endmodule
